// File: rtl/spi_frame_receiver.sv
// SPI slave deserializer: oversamples sclk_n/cs_n/mosi in the clk domain and
// rebuilds FRAME_BITS-bit frames, delivering the low DATA_BITS as one sample.
module spi_frame_receiver #(
    parameter int FRAME_BITS  = 16,
    parameter int DATA_BITS   = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_a,
    input  logic                 ena,
    input  logic                 sclk_n,
    input  logic                 cs_n,
    input  logic                 mosi,
    output logic [DATA_BITS-1:0] sample,
    output logic                 sample_vld,
    output logic                 frame_err,
    output logic                 busy,
    output logic [7:0]           frame_cnt
);
    localparam int CW = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, ERR} state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt, cnt_tmp;
    logic [FRAME_BITS-1:0]  shift, shift_nxt;
    logic [DATA_BITS-1:0]   sample_nxt;
    logic                   vld_nxt, err_nxt;
    logic [7:0]             fcnt_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_prev;
    logic                   sclk_s, cs_s, mosi_s, cap;

    // Lines idle high, so the synchronizers preset to 1 to avoid a false edge out of reset.
    always_ff @(posedge clk) begin
        if (rst_a) begin
            sclk_sync <= '1;
            cs_sync   <= '1;
            mosi_sync <= '1;
            sclk_prev <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_n};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_s;
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign cap    = sclk_s & ~sclk_prev;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        cnt_tmp    = cnt;
        shift_nxt  = shift;
        sample_nxt = sample;
        vld_nxt    = 1'b0;
        err_nxt    = 1'b0;
        fcnt_nxt   = frame_cnt;
        if (!ena) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!cs_s) begin
                        state_nxt = SHIFT;
                        cnt_nxt   = '0;
                    end
                end
                SHIFT: begin
                    // The bit is taken first; the cs_n rule then sees the updated counter.
                    if (cap) begin
                        shift_nxt = {shift[FRAME_BITS-2:0], mosi_s};
                        if (cnt == CW'(FRAME_BITS - 1)) begin
                            sample_nxt = shift_nxt[DATA_BITS-1:0];
                            vld_nxt    = 1'b1;
                            fcnt_nxt   = frame_cnt + 8'd1;
                            cnt_tmp    = '0;
                        end else begin
                            cnt_tmp = cnt + 1'b1;
                        end
                    end
                    cnt_nxt = cnt_tmp;
                    if (cs_s) begin
                        state_nxt = IDLE;
                        err_nxt   = (cnt_tmp != '0);
                        cnt_nxt   = '0;
                    end
                end
                ERR: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_a) begin
            state      <= IDLE;
            cnt        <= '0;
            shift      <= '0;
            sample     <= '0;
            sample_vld <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            shift      <= shift_nxt;
            sample     <= sample_nxt;
            sample_vld <= vld_nxt;
            frame_err  <= err_nxt;
            busy       <= (state_nxt != IDLE);
            frame_cnt  <= fcnt_nxt;
        end
    end
endmodule

// File: tb/tb_spi_frame_receiver.sv
// Scoreboard bench: stimulus pushes expected samples/errors, a monitor pops on each pulse.
module tb_spi_frame_receiver;
    logic        clk = 1'b0;
    logic        rst_a, ena, sclk_n, cs_n, mosi;
    logic [11:0] sample;
    logic        sample_vld, frame_err, busy;
    logic [7:0]  frame_cnt;

    typedef struct {
        logic [11:0] data;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          err_exp   = 0;
    int          err_seen  = 0;
    int          errors    = 0;
    int          checks    = 0;
    longint      cyc       = 0;
    longint      vld_t     = 0;
    longint      vld_t_prev = 0;
    logic [11:0] exp_last  = '0;
    logic [7:0]  exp_cnt   = '0;

    spi_frame_receiver dut (
        .clk(clk), .rst_a(rst_a), .ena(ena), .sclk_n(sclk_n), .cs_n(cs_n), .mosi(mosi),
        .sample(sample), .sample_vld(sample_vld), .frame_err(frame_err), .busy(busy),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst_a && sample_vld) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_vld", 32'(sample), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sample", 32'(sample), 32'(e.data));
                chk("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
                chk("vld_err_overlap", 32'(frame_err), 32'd0);
                exp_last   = e.data;
                vld_t_prev = vld_t;
                vld_t      = cyc;
            end
        end
        if (!rst_a && frame_err) begin
            err_seen++;
            chk("err_expected", 32'(err_exp > 0), 32'd1);
            if (err_exp > 0) err_exp--;
            chk("sample_held", 32'(sample), 32'(exp_last));
        end
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        wclk(4);
    endtask

    task automatic cs_high();
        cs_n = 1'b1;
        wclk(8);
    endtask

    task automatic send_bit(input logic b, input int half);
        mosi   = b;
        sclk_n = 1'b0;
        wclk(half);
        sclk_n = 1'b1;
        wclk(half);
    endtask

    // Sends 16 bits MSB first within an already-low cs_n; queues the expected sample.
    task automatic send_bits16(input logic [15:0] d, input logic [11:0] want, input int half);
        exp_t e;
        exp_cnt = exp_cnt + 8'd1;
        e.data  = want;
        e.cnt   = exp_cnt;
        exp_q.push_back(e);
        for (int i = 15; i >= 0; i--) send_bit(d[i], half);
    endtask

    task automatic frame(input logic [15:0] d, input logic [11:0] want, input int half);
        cs_low();
        send_bits16(d, want, half);
        cs_high();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || err_exp != 0) && n < 400) begin
            wclk(1);
            n++;
        end
        chk(name, 32'(exp_q.size() + err_exp), 32'd0);
    endtask

    task automatic do_reset();
        rst_a = 1'b1;
        cs_n  = 1'b1;
        wclk(1);
        chk("rst_sample", 32'(sample), 32'd0);
        chk("rst_vld", 32'(sample_vld), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(frame_cnt), 32'd0);
        exp_cnt  = '0;
        exp_last = '0;
        rst_a    = 1'b0;
        wclk(4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; ena = 1'b0; sclk_n = 1'b1; cs_n = 1'b1; mosi = 1'b0;
        wclk(3);
        do_reset();
        ena = 1'b1;
        wclk(2);

        // Single frame at 8-clk SCLK period.
        frame(16'hA5C3, 12'h5C3, 4);
        drain("t1_drain");
        chk("t1_cnt", 32'(frame_cnt), 32'd1);
        chk("t1_busy_idle", 32'(busy), 32'd0);
        chk("t1_no_err", 32'(err_seen), 32'd0);

        // Back-to-back frames under one cs_n low window; cnt continues from test 1.
        cs_low();
        chk("t2_busy", 32'(busy), 32'd1);
        send_bits16(16'h0FFF, 12'hFFF, 4);
        send_bits16(16'h1001, 12'h001, 4);
        cs_high();
        drain("t2_drain");
        chk("t2_gap", 32'(vld_t - vld_t_prev), 32'd128);
        chk("t2_cnt", 32'(frame_cnt), 32'd3);

        // Short frame: 9 edges then release.
        err_exp++;
        cs_low();
        for (int i = 0; i < 9; i++) send_bit(i[0], 4);
        cs_high();
        drain("t3_drain");
        chk("t3_err_once", 32'(err_seen), 32'd1);
        chk("t3_sample", 32'(sample), 32'h001);
        chk("t3_cnt", 32'(frame_cnt), 32'd3);

        // ena dropped mid-frame, then a clean frame.
        cs_low();
        for (int i = 0; i < 8; i++) send_bit(1'b1, 4);
        ena = 1'b0;
        wclk(4);
        chk("t5_busy_off", 32'(busy), 32'd0);
        cs_n = 1'b1;
        wclk(6);
        ena = 1'b1;
        wclk(4);
        frame(16'h0123, 12'h123, 4);
        drain("t5_drain");
        chk("t5_no_err", 32'(err_seen), 32'd1);
        chk("t5_cnt", 32'(frame_cnt), 32'd4);

        // Reset mid-frame after 5 edges, then a full frame.
        cs_low();
        for (int i = 0; i < 5; i++) send_bit(1'b0, 4);
        do_reset();
        frame(16'hBEEF, 12'hEEF, 4);
        drain("t6_drain");
        chk("t6_cnt", 32'(frame_cnt), 32'd1);

        // 256 good frames from a clean count: wraps to 0 on the last one.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] lo;
            lo = 8'(i);
            frame({8'h5A, lo}, {4'hA, lo}, 2);
        end
        drain("t4_drain");
        chk("t4_wrap", 32'(frame_cnt), 32'd0);
        chk("t4_no_err", 32'(err_seen), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
